coef_vector_assembler: RTL and testbench
========================================

// Module: coef_vector_assembler
// PURPOSE
//  Sits directly upstream of the symbols-to-bits decision stage. Accepts the sparse
//  OMP solver result as a stream of (position, value) coefficient pairs and builds
//  the dense N*DATA_WIDTH coefficient vector, with unselected positions set to zero.
//  It then presents the vector with a valid/ready handshake and holds it stable
//  until the downstream stage consumes it.
// PARAMETERS
//  N                  16  number of coefficients per frame
//  DATA_WIDTH         16  coefficient width, two's complement (192 = 1.5)
//  BITS_FOR_POSITION   4  width of coef_pos; must satisfy 2**BITS_FOR_POSITION >= N
//  K_MAX              16  max coefficients accepted per frame (1..N)
// PORTS
//  clk          in   1                 rising-edge clock
//  rst_n        in   1                 synchronous reset, active low
//  start        in   1                 begin new frame; honoured only in IDLE
//  coef_valid   in   1                 coefficient pair present
//  coef_ready   out  1                 assembler accepts pair
//  coef_pos     in   BITS_FOR_POSITION slot index, 0..N-1
//  coef_value   in   DATA_WIDTH        coefficient value
//  coef_last    in   1                 final pair of the frame
//  x_out        out  DATA_WIDTH*N      dense vector; slot i at [N*DW-i*DW-1 -: DW]
//  x_valid      out  1                 x_out complete and stable
//  x_ready      in   1                 downstream consumes x_out
//  err_pos      out  1                 sticky: a pair with pos >= N was discarded
//  err_count    out  1                 sticky: frame closed by K_MAX, not coef_last
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE, vector=0, coef_ready=0, x_valid=0,
//   err_pos=0, err_count=0, accept counter=0. Reset mid-frame discards the frame.
//  FSM is IDLE -> COLLECT -> HOLD -> IDLE.
//   IDLE:    coef_ready=0, x_valid=0. If start=1: clear the vector and the counter,
//            clear both error flags, go to COLLECT.
//   COLLECT: coef_ready=1. A handshake is coef_valid & coef_ready.
//            - Handshake with pos < N: write coef_value into slot pos.
//              A repeated pos overwrites; last write wins.
//            - Handshake with pos >= N: value discarded, err_pos set. The pair still
//              counts toward K_MAX and still honours coef_last.
//            - Counter increments on every handshake.
//            - Go to HOLD if coef_last=1, or if this handshake makes counter == K_MAX.
//              In the K_MAX case without coef_last, set err_count.
//   HOLD:    x_valid=1, coef_ready=0, x_out frozen. On x_ready=1, go to IDLE at the
//            next edge. x_valid drops in IDLE; x_out keeps its value until next start.
//  Latency: x_valid rises on the edge after the closing handshake.
//   Minimum frame is 1 cycle IDLE + 1 handshake + 1 cycle HOLD.
//  start outside IDLE is ignored. coef_valid outside COLLECT is ignored, with no
//   side effects.
//  x_ready may be held high permanently; HOLD then lasts exactly one cycle.
//  Registered outputs: coef_ready, x_valid, x_out and the error flags.
//   No combinational path from any input to any output.
//  Error flags hold from when they are set until the next start or reset.
// TESTING
//  1. N=16, start, then pairs (3,192),(7,-64),(12,200) with last on the third
//     -> slots 3=192, 7=-64 (0xFFC0), 12=200, all others 0; x_valid one cycle
//     after the third handshake.
//  2. Pairs (5,10) then (5,300,last) -> slot 5=300, err flags 0.
//  3. Pair (pos=17 with BITS_FOR_POSITION=5, N=16) then (2,192,last)
//     -> err_pos=1, slot 2=192, every other slot 0.
//  4. K_MAX=2: three pairs sent, none with last -> the first two are accepted,
//     coef_ready=0 on the third, x_valid=1, err_count=1.
//  5. x_ready held low 10 cycles in HOLD with coef_valid/start toggling
//     -> x_out and x_valid unchanged; x_ready=1 -> IDLE next cycle.
//  6. rst_n=0 for one edge mid-COLLECT after (4,99)
//     -> IDLE, x_out=0, x_valid=0; a new frame does not contain 99.

Source files
------------

// File: rtl/coef_vector_assembler.sv
// Collects sparse (position, value) coefficient pairs into a dense, zero-filled
// vector and holds it behind a valid/ready handshake until downstream consumes it.
module coef_vector_assembler #(
  parameter int N                 = 16,
  parameter int DATA_WIDTH        = 16,
  parameter int BITS_FOR_POSITION = 4,
  parameter int K_MAX             = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         coef_valid,
  output logic                         coef_ready,
  input  logic [BITS_FOR_POSITION-1:0] coef_pos,
  input  logic [DATA_WIDTH-1:0]        coef_value,
  input  logic                         coef_last,
  output logic [DATA_WIDTH*N-1:0]      x_out,
  output logic                         x_valid,
  input  logic                         x_ready,
  output logic                         err_pos,
  output logic                         err_count,
  output logic [1:0]                   dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
  // coef_ready/x_valid are flops, so ready never depends combinationally on valid.
  localparam int CW = $clog2(K_MAX + 1);
  localparam logic [BITS_FOR_POSITION:0] LP_N    = (BITS_FOR_POSITION + 1)'(N);
  localparam logic [CW-1:0]              LP_KMAX = CW'(K_MAX);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_vec [N];
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_count_inc;
  logic                  r_coef_ready;
  logic                  r_x_valid;
  logic                  r_err_pos;
  logic                  r_err_count;
  logic                  w_hs;
  logic                  w_pos_ok;
  logic                  w_hit_kmax;
  logic                  w_close;
  logic                  w_start;

  // r_coef_ready is high exactly while in COLLECT, so it doubles as the state qualifier.
  assign w_hs        = coef_valid & r_coef_ready;
  assign w_pos_ok    = ({1'b0, coef_pos} < LP_N);
  assign w_count_inc = r_count + CW'(1);
  assign w_hit_kmax  = (w_count_inc == LP_KMAX);
  assign w_close     = w_hs & (coef_last | w_hit_kmax);
  assign w_start     = (r_state == S_IDLE) & start;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start)   w_next = S_COLLECT;
      S_COLLECT: if (w_close) w_next = S_HOLD;
      S_HOLD:    if (x_ready) w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_coef_ready <= 1'b0;
      r_x_valid    <= 1'b0;
      r_err_pos    <= 1'b0;
      r_err_count  <= 1'b0;
      r_count      <= '0;
      for (int i = 0; i < N; i++) r_vec[i] <= '0;
    end else begin
      r_coef_ready <= (w_next == S_COLLECT);
      r_x_valid    <= (w_next == S_HOLD);
      if (w_start) begin
        r_err_pos   <= 1'b0;
        r_err_count <= 1'b0;
        r_count     <= '0;
        for (int i = 0; i < N; i++) r_vec[i] <= '0;
      end else if (w_hs) begin
        r_count <= w_count_inc;
        if (!w_pos_ok) r_err_pos <= 1'b1;
        if (w_hit_kmax && !coef_last) r_err_count <= 1'b1;
        // Out-of-range positions match no slot and are dropped here.
        for (int i = 0; i < N; i++)
          if (coef_pos == BITS_FOR_POSITION'(i)) r_vec[i] <= coef_value;
      end
    end
  end

  // Slot 0 occupies the most significant word.
  always_comb begin
    x_out = '0;
    for (int i = 0; i < N; i++)
      x_out[N*DATA_WIDTH - i*DATA_WIDTH - 1 -: DATA_WIDTH] = r_vec[i];
  end

  assign coef_ready = r_coef_ready;
  assign x_valid    = r_x_valid;
  assign err_pos    = r_err_pos;
  assign err_count  = r_err_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_coef_vector_assembler.sv
// Directed bench for coef_vector_assembler (N=16, 5-bit positions, K_MAX=4) with a
// reference vector model and an expected-output queue.
module tb_coef_vector_assembler;

  localparam int N  = 16;
  localparam int DW = 16;
  localparam int PW = 5;
  localparam int K  = 4;
  localparam int VW = N * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          coef_valid = 1'b0;
  logic          coef_ready;
  logic [PW-1:0] coef_pos = '0;
  logic [DW-1:0] coef_value = '0;
  logic          coef_last = 1'b0;
  logic [VW-1:0] x_out;
  logic          x_valid;
  logic          x_ready = 1'b0;
  logic          err_pos;
  logic          err_count;
  logic [1:0]    dbg_state;

  coef_vector_assembler #(
    .N(N), .DATA_WIDTH(DW), .BITS_FOR_POSITION(PW), .K_MAX(K)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .coef_valid(coef_valid), .coef_ready(coef_ready),
    .coef_pos(coef_pos), .coef_value(coef_value), .coef_last(coef_last),
    .x_out(x_out), .x_valid(x_valid), .x_ready(x_ready),
    .err_pos(err_pos), .err_count(err_count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard and model
  logic [VW-1:0] exp_q[$];
  logic [DW-1:0] m_vec [N];
  int            m_cnt;
  logic          m_ep;
  logic          m_ec;
  logic [VW-1:0] last_vec;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] pack_model();
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[VW - i*DW - 1 -: DW] = m_vec[i];
    return v;
  endfunction

  // driver tasks, all entered and left just after a falling edge
  task automatic start_frame();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < N; i++) m_vec[i] = '0;
    m_cnt = 0;
    m_ep  = 1'b0;
    m_ec  = 1'b0;
    chk("ready_after_start", VW'(coef_ready), VW'(1));
  endtask

  task automatic send_pair(input logic [PW-1:0] pos, input logic [DW-1:0] val, input logic last);
    int n;
    n = 0;
    coef_valid = 1'b1;
    coef_pos   = pos;
    coef_value = val;
    coef_last  = last;
    while (!coef_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", VW'(coef_ready), VW'(1));
    @(negedge clk);
    coef_valid = 1'b0;
    coef_last  = 1'b0;
    if (pos < N) m_vec[pos] = val;
    else         m_ep = 1'b1;
    m_cnt++;
    if (last || m_cnt == K) begin
      if (!last) m_ec = 1'b1;
      exp_q.push_back(pack_model());
    end
  endtask

  task automatic expect_output(input string tag);
    int n;
    logic [VW-1:0] e;
    n = 0;
    while (!x_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, VW'(n), VW'(0));
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, VW'(0), VW'(1));
    end else begin
      e = exp_q.pop_front();
      last_vec = e;
      chk({tag, "_x_out"}, x_out, e);
      chk({tag, "_err_pos"}, VW'(err_pos), VW'(m_ep));
      chk({tag, "_err_count"}, VW'(err_count), VW'(m_ec));
      chk({tag, "_ready_low"}, VW'(coef_ready), VW'(0));
    end
  endtask

  task automatic consume(input string tag);
    x_ready = 1'b1;
    @(negedge clk);
    x_ready = 1'b0;
    chk({tag, "_valid_drop"}, VW'(x_valid), VW'(0));
    chk({tag, "_idle"}, VW'(dbg_state), VW'(0));
    chk({tag, "_x_out_kept"}, x_out, last_vec);
  endtask

  initial begin
    // reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_x_valid", VW'(x_valid), VW'(0));
    chk("rst_ready", VW'(coef_ready), VW'(0));
    chk("rst_x_out", x_out, '0);
    chk("rst_errs", VW'({err_pos, err_count}), VW'(0));
    chk("rst_state", VW'(dbg_state), VW'(0));

    // three sparse pairs, negative value in the middle
    start_frame();
    send_pair(5'd3, 16'd192, 1'b0);
    send_pair(5'd7, 16'hFFC0, 1'b0);
    chk("t1_no_early_valid", VW'(x_valid), VW'(0));
    send_pair(5'd12, 16'd200, 1'b1);
    expect_output("t1");
    consume("t1");

    // repeated position, last write wins
    start_frame();
    send_pair(5'd5, 16'd10, 1'b0);
    send_pair(5'd5, 16'd300, 1'b1);
    expect_output("t2");
    consume("t2");

    // out-of-range position discarded, err_pos set
    start_frame();
    send_pair(5'd17, 16'd77, 1'b0);
    send_pair(5'd2, 16'd192, 1'b1);
    expect_output("t3");
    consume("t3");

    // K_MAX closes the frame without last; a fifth pair must be refused
    start_frame();
    send_pair(5'd0, 16'd1, 1'b0);
    send_pair(5'd1, 16'd2, 1'b0);
    send_pair(5'd2, 16'd3, 1'b0);
    send_pair(5'd15, 16'd4, 1'b0);
    coef_valid = 1'b1;
    coef_pos   = 5'd6;
    coef_value = 16'd55;
    @(negedge clk);
    chk("t4_ready_refused", VW'(coef_ready), VW'(0));
    coef_valid = 1'b0;
    expect_output("t4");
    consume("t4");

    // last arriving exactly on the K_MAX-th pair is not a count error
    start_frame();
    for (int i = 0; i < K - 1; i++) send_pair(PW'(i + 8), DW'(i + 100), 1'b0);
    send_pair(5'd14, 16'h8000, 1'b1);
    expect_output("t4b");
    consume("t4b");

    // HOLD stall with start/coef_valid toggling
    start_frame();
    send_pair(5'd9, 16'd1234, 1'b1);
    expect_output("t5");
    for (int i = 0; i < 10; i++) begin
      coef_valid = i[0];
      start      = ~i[0];
      @(negedge clk);
      chk("t5_hold_x_out", x_out, last_vec);
      chk("t5_hold_valid", VW'(x_valid), VW'(1));
    end
    coef_valid = 1'b0;
    start      = 1'b0;
    consume("t5");

    // reset mid-collect discards the partial frame
    start_frame();
    send_pair(5'd4, 16'd99, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_x_out", x_out, '0);
    chk("t6_x_valid", VW'(x_valid), VW'(0));
    chk("t6_ready", VW'(coef_ready), VW'(0));
    chk("t6_state", VW'(dbg_state), VW'(0));
    start_frame();
    send_pair(5'd1, 16'd5, 1'b1);
    expect_output("t6");
    consume("t6");

    // final report
    chk("queue_drained", VW'(exp_q.size()), VW'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
